wave_synth: RTL and testbench
=============================

# wave_synth

Dual-channel DDS regenerator that turns the spectral classification result (frequency code plus sine/triangle flag for waves A and B) back into two separated analog waveforms. It sits downstream of the FFT frequency/shape detector and drives two 8-bit parallel DACs. Both channels are restarted phase-coherently each time a new classification result becomes valid. Channel B carries a live phase offset relative to A.

## Interface
- STEP_5K, 429497: phase increment for one 5 kHz frequency code unit; round(5000·2^32/f_clk), with the default for 50 MHz.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wave_vaild  in  1  classification result valid from the detector; level signal, high while the result is held.
- waveA_freq  in  8  wave A frequency code in 5 kHz units.
- waveA_sin  in  1  1 = A is sine, 0 = A is triangle.
- waveB_freq  in  8  wave B frequency code in 5 kHz units.
- waveB_sin  in  1  1 = B is sine, 0 = B is triangle.
- phase_off  in  8  B phase lead over A, in units of 360°/256; sampled every cycle.
- dac_a  out  8  channel A sample, offset binary, midscale 128.
- dac_b  out  8  channel B sample, offset binary, midscale 128.
- running  out  1  high while the state is RUN.

## Operation
- Input edge detect: wave_vaild is registered into vld_d0. Rise = wave_vaild & ~vld_d0. Fall = ~wave_vaild & vld_d0.
- Three states:
  - IDLE: accumulators held at 0; dac_a = dac_b = 128; running = 0. On rise, capture the freq codes and sin flags into local registers and go to LOAD.
  - LOAD: one cycle. Compute inc_a = freqA·STEP_5K and inc_b = freqB·STEP_5K, each 32-bit and truncated. Clear both accumulators. Go to RUN.
  - RUN: acc_a += inc_a and acc_b += inc_b every cycle, with modulo-2^32 wrap. On fall, go to IDLE. A rise is impossible without a prior fall.
- Lookup address: addr_a = acc_a[31:24]; addr_b = acc_b[31:24] + phase_off (8-bit wrap).
- Sine: an internal 256×8 ROM with rom[k] = round(128 + 127·sin(2πk/256)). rom[0] = 128, rom[64] = 255, rom[128] = 128, rom[192] = 1.
- Triangle: t = addr + 64 (8-bit wrap).
  - t[7] = 0: value = {t[6:0], 0}.
  - t[7] = 1: value = ~{t[6:0], 0}.
  - Results: addr 0 → 128, addr 64 → 255, addr 192 → 0. The triangle is in phase with the sine.
- Shape per channel selects between the sine and triangle values using the captured sin flag.
- Mute: a channel whose captured freq code is 0 outputs a constant 128, regardless of shape or phase_off.
- Captured codes and flags do not change during RUN, even if the inputs change. phase_off is the only live input.

## Timing
- Reset: state IDLE; accumulators, incs and captured registers 0; vld_d0 = 0; dac_a = dac_b = 128; running = 0. Reset has priority in any state, including mid-RUN.
- Rise seen at edge N (vld_d0 goes 1): state = LOAD after N. RUN after N+1, with acc = 0 during the first RUN cycle. running is high from the N+2 edge onward.
- Pipeline: acc/offset value → ROM/triangle register → output register. dac reflects an acc value 2 cycles after that value is present. The first RUN acc value (0) appears on dac at the 2nd edge after RUN entry.
- phase_off change takes effect on dac_b 2 cycles later, without glitching A.
- Fall seen at edge M: state = IDLE after M. dac forced to 128 on the M+1 edge. Pipeline contents are discarded.
- Both channels are reset by the same LOAD cycle. Their accumulators are therefore exactly aligned, and A/B phase relation is defined only by phase_off.
- Max freq code 255 (1.275 MHz) needs no special handling. Aliasing is the user's concern.

## Test plan
- Reset then idle: rst high for 3 cycles, wave_vaild = 0 → dac_a = dac_b = 128, running = 0 for 100 cycles.
- Sine A, code 4, with wave_vaild rising:
  - running is high at the rise+2 edge.
  - acc_a increments by 1717988 per cycle.
  - dac_a peaks at 255, troughs at 1, period ≈ 2500 cycles at 50 MHz.
- Triangle B, code 6, phase_off = 0, A sine code 2:
  - dac_b reaches 255 at the same cycle index as a sine code 6 would.
  - Consecutive dac_b steps are monotonic between 0 and 255.
- Phase offset: A and B both sine code 5, phase_off = 64 → dac_b leads dac_a by a quarter period. When dac_a = 128 rising, dac_b = 255 ±2.
- Mute and input stability:
  - B code 0 → dac_b constant 128.
  - Changing waveA_freq inputs during RUN does not alter dac_a's period.
- Restart and mid-run reset:
  - Drop wave_vaild → dac = 128 two edges later.
  - Re-raise with new codes → accumulators restart from 0 coherently.
  - Assert rst during RUN → next edge outputs 128, state IDLE.

Source files
------------

// File: rtl/wave_synth.sv
// wave_synth: dual-channel DDS that regenerates waves A and B from the
// frequency/shape classification result and drives two 8-bit DACs.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   wave_vaild  classification result valid (level, held high)
//   waveA_freq  wave A frequency code, 5 kHz units
//   waveA_sin   1 = A sine, 0 = A triangle
//   waveB_freq  wave B frequency code, 5 kHz units
//   waveB_sin   1 = B sine, 0 = B triangle
//   phase_off   live B phase lead over A, 360/256 degree units
//   dac_a       channel A sample, offset binary (midscale 128)
//   dac_b       channel B sample, offset binary (midscale 128)
//   running     high while the generator is running
module wave_synth #(
   parameter logic [31:0] STEP_5K = 32'd429497
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wave_vaild,
   input  logic [7:0] waveA_freq,
   input  logic       waveA_sin,
   input  logic [7:0] waveB_freq,
   input  logic       waveB_sin,
   input  logic [7:0] phase_off,
   output logic [7:0] dac_a,
   output logic [7:0] dac_b,
   output logic       running
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        vld_d0;
   logic        rise;
   logic        fall;
   logic [7:0]  freq_a_cap;
   logic [7:0]  freq_b_cap;
   logic        sin_a_cap;
   logic        sin_b_cap;
   logic [31:0] inc_a;
   logic [31:0] inc_b;
   logic [31:0] acc_a;
   logic [31:0] acc_b;
   logic [7:0]  addr_a;
   logic [7:0]  addr_b;
   logic [7:0]  shp_a;
   logic [7:0]  shp_b;

   // First quadrant of the sine, round(127*sin(2*pi*j/256)) for j = 0..64.
   function automatic logic [6:0] quarter_sin(input logic [6:0] j);
      logic [6:0] m;
      case (j)
         7'd0:  m = 7'd0;    7'd1:  m = 7'd3;    7'd2:  m = 7'd6;    7'd3:  m = 7'd9;
         7'd4:  m = 7'd12;   7'd5:  m = 7'd16;   7'd6:  m = 7'd19;   7'd7:  m = 7'd22;
         7'd8:  m = 7'd25;   7'd9:  m = 7'd28;   7'd10: m = 7'd31;   7'd11: m = 7'd34;
         7'd12: m = 7'd37;   7'd13: m = 7'd40;   7'd14: m = 7'd43;   7'd15: m = 7'd46;
         7'd16: m = 7'd49;   7'd17: m = 7'd51;   7'd18: m = 7'd54;   7'd19: m = 7'd57;
         7'd20: m = 7'd60;   7'd21: m = 7'd63;   7'd22: m = 7'd65;   7'd23: m = 7'd68;
         7'd24: m = 7'd71;   7'd25: m = 7'd73;   7'd26: m = 7'd76;   7'd27: m = 7'd78;
         7'd28: m = 7'd81;   7'd29: m = 7'd83;   7'd30: m = 7'd85;   7'd31: m = 7'd88;
         7'd32: m = 7'd90;   7'd33: m = 7'd92;   7'd34: m = 7'd94;   7'd35: m = 7'd96;
         7'd36: m = 7'd98;   7'd37: m = 7'd100;  7'd38: m = 7'd102;  7'd39: m = 7'd104;
         7'd40: m = 7'd106;  7'd41: m = 7'd107;  7'd42: m = 7'd109;  7'd43: m = 7'd111;
         7'd44: m = 7'd112;  7'd45: m = 7'd113;  7'd46: m = 7'd115;  7'd47: m = 7'd116;
         7'd48: m = 7'd117;  7'd49: m = 7'd118;  7'd50: m = 7'd120;  7'd51: m = 7'd121;
         7'd52: m = 7'd122;  7'd53: m = 7'd122;  7'd54: m = 7'd123;  7'd55: m = 7'd124;
         7'd56: m = 7'd125;  7'd57: m = 7'd125;  7'd58: m = 7'd126;  7'd59: m = 7'd126;
         7'd60: m = 7'd126;  7'd61: m = 7'd127;  7'd62: m = 7'd127;  7'd63: m = 7'd127;
         default: m = 7'd127;
      endcase
      return m;
   endfunction

   // Full 256-entry sine built from the quarter table by mirror symmetry:
   // the second quadrant reads the table backwards, the lower half subtracts.
   function automatic logic [7:0] sine_lookup(input logic [7:0] addr);
      logic [6:0] j;
      logic [6:0] m;
      j = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
      m = quarter_sin(j);
      return addr[7] ? (8'd128 - {1'b0, m}) : (8'd128 + {1'b0, m});
   endfunction

   // Triangle shifted by a quarter turn so it peaks where the sine peaks.
   function automatic logic [7:0] tri_lookup(input logic [7:0] addr);
      logic [7:0] t;
      t = addr + 8'd64;
      return t[7] ? ~{t[6:0], 1'b0} : {t[6:0], 1'b0};
   endfunction

   assign rise = wave_vaild & ~vld_d0;
   assign fall = ~wave_vaild & vld_d0;

   // State register and valid-edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         vld_d0 <= 1'b0;
      end else begin
         state  <= next_state;
         vld_d0 <= wave_vaild;
      end
   end

   // Next-state logic and lookup addresses; only B carries the live offset.
   always_comb begin
      next_state = state;
      addr_a     = acc_a[31:24];
      addr_b     = acc_b[31:24] + phase_off;
      case (state)
         IDLE: begin
            if (rise) next_state = LOAD;
            else      next_state = IDLE;
         end
         LOAD: begin
            if (fall) next_state = IDLE;
            else      next_state = RUN;
         end
         RUN: begin
            if (fall) next_state = IDLE;
            else      next_state = RUN;
         end
         default: next_state = IDLE;
      endcase
   end

   // Capture of the classification result, increment setup and phase
   // accumulation; both accumulators share the same clear cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq_a_cap <= 8'd0;
         freq_b_cap <= 8'd0;
         sin_a_cap  <= 1'b0;
         sin_b_cap  <= 1'b0;
         inc_a      <= 32'd0;
         inc_b      <= 32'd0;
         acc_a      <= 32'd0;
         acc_b      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               acc_a <= 32'd0;
               acc_b <= 32'd0;
               if (rise) begin
                  freq_a_cap <= waveA_freq;
                  freq_b_cap <= waveB_freq;
                  sin_a_cap  <= waveA_sin;
                  sin_b_cap  <= waveB_sin;
               end
            end
            LOAD: begin
               inc_a <= {24'd0, freq_a_cap} * STEP_5K;
               inc_b <= {24'd0, freq_b_cap} * STEP_5K;
               acc_a <= 32'd0;
               acc_b <= 32'd0;
            end
            RUN: begin
               acc_a <= acc_a + inc_a;
               acc_b <= acc_b + inc_b;
            end
            default: begin
               acc_a <= 32'd0;
               acc_b <= 32'd0;
            end
         endcase
      end
   end

   // Waveform stage: shape lookup per channel, midscale outside RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         shp_a <= 8'd128;
         shp_b <= 8'd128;
      end else if (state == RUN) begin
         shp_a <= sin_a_cap ? sine_lookup(addr_a) : tri_lookup(addr_a);
         shp_b <= sin_b_cap ? sine_lookup(addr_b) : tri_lookup(addr_b);
      end else begin
         shp_a <= 8'd128;
         shp_b <= 8'd128;
      end
   end

   // Output stage: a zero frequency code mutes its channel to midscale,
   // and leaving RUN discards whatever the waveform stage still holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         dac_a   <= 8'd128;
         dac_b   <= 8'd128;
         running <= 1'b0;
      end else if (state == RUN) begin
         dac_a   <= (freq_a_cap == 8'd0) ? 8'd128 : shp_a;
         dac_b   <= (freq_b_cap == 8'd0) ? 8'd128 : shp_b;
         running <= 1'b1;
      end else begin
         dac_a   <= 8'd128;
         dac_b   <= 8'd128;
         running <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wave_synth.sv
// Self-checking bench for wave_synth: a behavioural model predicts the DAC
// samples from edge counts and real-valued sine/triangle formulas, and
// directed scenarios add hand-computed sample values.
module tb_wave_synth;

   logic       clk;
   logic       rst;
   logic       wave_vaild;
   logic [7:0] waveA_freq;
   logic       waveA_sin;
   logic [7:0] waveB_freq;
   logic       waveB_sin;
   logic [7:0] phase_off;
   logic [7:0] dac_a;
   logic [7:0] dac_b;
   logic       running;

   int checks = 0;
   int errors = 0;

   wave_synth dut (
      .clk        (clk),
      .rst        (rst),
      .wave_vaild (wave_vaild),
      .waveA_freq (waveA_freq),
      .waveA_sin  (waveA_sin),
      .waveB_freq (waveB_freq),
      .waveB_sin  (waveB_sin),
      .phase_off  (phase_off),
      .dac_a      (dac_a),
      .dac_b      (dac_b),
      .running    (running)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int sine_ref(input int a);
      real x;
      x = 128.0 + 127.0 * $sin(6.283185307179586 * real'(a) / 256.0);
      return $rtoi(x + 0.5);
   endfunction

   function automatic int tri_ref(input int a);
      int t;
      t = (a + 64) % 256;
      return (t < 128) ? (2 * t) : (255 - 2 * (t - 128));
   endfunction

   // Sample k of a channel started at phase 0, plus a lookup offset.
   function automatic int chan_ref(input int code, input bit is_sin, input longint k, input int off);
      longint inc;
      longint acc;
      int     a;
      if (code == 0) return 128;
      inc = (longint'(code) * 64'sd429497) % 64'sd4294967296;
      acc = (k * inc) % 64'sd4294967296;
      a   = (int'(acc / 64'sd16777216) + off) % 256;
      return is_sin ? sine_ref(a) : tri_ref(a);
   endfunction

   longint ecnt = 0;
   longint n_edge = 0;
   longint m_edge = 0;
   bit     have = 1'b0;
   bit     in_run = 1'b0;
   bit     prev_v = 1'b0;
   bit     model_ok = 1'b0;
   bit     m_rise;
   bit     m_fall;
   int     cap_fa = 0;
   int     cap_fb = 0;
   bit     cap_sa = 1'b0;
   bit     cap_sb = 1'b0;
   int     ph_prev = 0;
   int     exp_a = 128;
   int     exp_b = 128;
   int     exp_run = 0;

   // Model: rise edge N starts a session, fall edge M ends it; samples are
   // valid on edges N+3..M, running on edges N+2..M.
   initial begin
      forever begin
         @(posedge clk);
         ecnt++;
         if (rst === 1'b1) begin
            have = 1'b0; in_run = 1'b0; prev_v = 1'b0; model_ok = 1'b1;
            exp_a = 128; exp_b = 128; exp_run = 0;
         end else begin
            m_rise = (wave_vaild === 1'b1) && !prev_v;
            m_fall = (wave_vaild !== 1'b1) && prev_v;
            prev_v = (wave_vaild === 1'b1);
            if (m_rise && !in_run) begin
               have = 1'b1; in_run = 1'b1; n_edge = ecnt; m_edge = longint'(1) <<< 60;
               cap_fa = int'(waveA_freq); cap_fb = int'(waveB_freq);
               cap_sa = waveA_sin; cap_sb = waveB_sin;
            end else if (m_fall && in_run) begin
               in_run = 1'b0; m_edge = ecnt;
            end
            exp_run = (have && ecnt >= n_edge + 2 && ecnt <= m_edge) ? 1 : 0;
            if (have && ecnt >= n_edge + 3 && ecnt <= m_edge) begin
               exp_a = chan_ref(cap_fa, cap_sa, ecnt - n_edge - 3, 0);
               exp_b = chan_ref(cap_fb, cap_sb, ecnt - n_edge - 3, ph_prev);
            end else begin
               exp_a = 128; exp_b = 128;
            end
         end
         ph_prev = int'(phase_off);
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("model dac_a", int'(dac_a), exp_a);
            check("model dac_b", int'(dac_b), exp_b);
            check("model running", int'(running), exp_run);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_codes(input int fa, input bit sa, input int fb, input bit sb, input int ph);
      waveA_freq = 8'(fa); waveA_sin = sa;
      waveB_freq = 8'(fb); waveB_sin = sb;
      phase_off  = 8'(ph);
   endtask

   // Drop valid; outputs must be midscale on the second edge.
   task automatic stop_run(input string tag);
      wave_vaild = 1'b0;
      step(2);
      check({tag, " stop dac_a"}, int'(dac_a), 128);
      check({tag, " stop dac_b"}, int'(dac_b), 128);
      check({tag, " stop running"}, int'(running), 0);
      step(2);
   endtask

   int first_pk;
   int first_tr;
   int max_a;
   int min_a;
   int non_mid_b;
   int prev_val;
   int last_dir;
   int dir;
   int bad_rev;

   initial begin
      rst = 1'b1; wave_vaild = 1'b0;
      set_codes(0, 1'b0, 0, 1'b0, 0);
      step(3);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (i == 99) begin
            check("idle dac_a", int'(dac_a), 128);
            check("idle dac_b", int'(dac_b), 128);
            check("idle running", int'(running), 0);
         end
      end

      // Sine A code 4, B muted; A inputs disturbed mid-run.
      set_codes(4, 1'b1, 0, 1'b1, 8'h37);
      wave_vaild = 1'b1;
      first_pk = -1; max_a = 0; min_a = 255; non_mid_b = 0;
      for (int j = 1; j <= 2600; j++) begin
         step(1);
         if (j == 2) check("sine4 running at rise+1", int'(running), 0);
         if (j == 3) check("sine4 running at rise+2", int'(running), 1);
         if (j == 5) begin
            waveA_freq = 8'd200; waveA_sin = 1'b0; waveB_freq = 8'd9; phase_off = 8'd99;
         end
         if (j == 14) check("sine4 sample k10", int'(dac_a), 131);
         if (dac_a == 8'd255 && first_pk < 0) first_pk = j;
         if (int'(dac_a) > max_a) max_a = int'(dac_a);
         if (int'(dac_a) < min_a) min_a = int'(dac_a);
         if (dac_b != 8'd128) non_mid_b++;
      end
      check("sine4 first peak index", first_pk, 600);
      check("sine4 max", max_a, 255);
      check("sine4 min", min_a, 1);
      check("mute B non-midscale count", non_mid_b, 0);
      stop_run("sine4");

      // Triangle B code 6, A sine code 2.
      set_codes(2, 1'b1, 6, 1'b0, 0);
      wave_vaild = 1'b1;
      first_pk = -1; first_tr = -1; bad_rev = 0; last_dir = 0; prev_val = 128;
      for (int j = 1; j <= 1400; j++) begin
         step(1);
         if (dac_b == 8'd255 && first_pk < 0) first_pk = j;
         if (dac_b == 8'd0 && first_tr < 0) first_tr = j;
         if (j >= 4 && int'(dac_b) != prev_val) begin
            dir = (int'(dac_b) > prev_val) ? 1 : -1;
            if (last_dir != 0 && dir != last_dir && prev_val != 255 && prev_val != 0) bad_rev++;
            last_dir = dir;
         end
         prev_val = int'(dac_b);
      end
      check("tri6 first peak index", first_pk, 421);
      check("tri6 first trough index", first_tr, 1254);
      check("tri6 direction reversals off extremes", bad_rev, 0);
      stop_run("tri6");

      // Quarter-period lead of B over A, then a live offset change.
      set_codes(5, 1'b1, 5, 1'b1, 64);
      wave_vaild = 1'b1;
      for (int j = 1; j <= 2020; j++) begin
         step(1);
         if (j == 4) begin
            check("phase64 dac_a k0", int'(dac_a), 128);
            check("phase64 dac_b k0", int'(dac_b), 255);
         end
         if (j == 2004) begin
            check("phase64 dac_a k2000", int'(dac_a), 128);
            check("phase64 dac_b k2000", int'(dac_b), 255);
         end
         if (j == 2010) phase_off = 8'd0;
         if (j == 2011) check("phase change before effect", int'(dac_b), 255);
         if (j == 2012) begin
            check("phase change effect dac_b", int'(dac_b), 131);
            check("phase change dac_a", int'(dac_a), 131);
         end
      end
      stop_run("phase");

      // Mid-run reset, automatic restart while valid is held, then restart
      // with new codes.
      set_codes(4, 1'b1, 3, 1'b0, 10);
      wave_vaild = 1'b1;
      step(50);
      rst = 1'b1;
      step(1);
      check("midrun rst dac_a", int'(dac_a), 128);
      check("midrun rst dac_b", int'(dac_b), 128);
      check("midrun rst running", int'(running), 0);
      rst = 1'b0;
      step(40);
      wave_vaild = 1'b0;
      step(3);
      set_codes(8, 1'b1, 8, 1'b1, 0);
      wave_vaild = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         step(1);
         if (j == 3) check("restart running", int'(running), 1);
         if (j == 14) begin
            check("restart dac_a k10", int'(dac_a), 134);
            check("restart dac_b k10", int'(dac_b), 134);
         end
      end
      stop_run("restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
